// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential radix-2 restoring divider. It divides an unsigned 2*DW-bit
//   dividend by an unsigned DW-bit divisor and resolves one quotient bit per
//   RUN cycle, MSB first. A non-zero divisor takes 2*DW RUN cycles. A zero
//   divisor takes a single RUN cycle and returns the saturated result with
//   div_zero set.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      dividend/divisor offered
//   in_ready   out  1      high only in IDLE (operation can be accepted)
//   dividend   in   2*DW   unsigned dividend
//   divisor    in   DW     unsigned divisor
//   out_valid  out  1      high only in DONE (result available)
//   out_ready  in   1      consumer accepts the result
//   quotient   out  2*DW   unsigned quotient
//   remainder  out  DW     unsigned remainder
//   div_zero   out  1      result came from a zero divisor
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   quotient,
    output logic [DW-1:0]     remainder,
    output logic              div_zero
);

    localparam int CW = $clog2(2 * DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;      // iteration counter, 0 .. 2*DW-1
    logic [DW-1:0]      prem_q;     // partial remainder, always < divisor
    logic [2*DW-1:0]    dvd_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DW-1:0]      dsr_q;      // captured divisor
    logic [2*DW-1:0]    quot_q;
    logic [DW-1:0]      rem_q;
    logic               dz_q;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    logic [DW:0]        shifted_d;
    logic               ge_d;
    logic [DW-1:0]      diff_d;
    logic [DW-1:0]      prem_d;
    logic [2*DW-1:0]    dvd_d;
    logic               last_d;

    always_comb begin
        shifted_d = {prem_q, dvd_q[2*DW-1]};
        ge_d      = (shifted_d >= {1'b0, dsr_q});
        // When ge_d holds the difference is below 2^DW, so DW bits suffice.
        diff_d    = shifted_d[DW-1:0] - dsr_q;
        prem_d    = ge_d ? diff_d : shifted_d[DW-1:0];
        dvd_d     = {dvd_q[2*DW-2:0], ge_d};
        last_d    = (cnt_q == CW'(2 * DW - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q   <= dividend;
                        dsr_q   <= divisor;
                        cnt_q   <= '0;
                        prem_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (dsr_q == '0) begin
                        // Zero divisor: no iterations. dvd_q still holds the
                        // untouched dividend because no step has run yet.
                        quot_q  <= '1;
                        rem_q   <= dvd_q[DW-1:0];
                        dz_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        prem_q <= prem_d;
                        dvd_q  <= dvd_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_d) begin
                            quot_q  <= dvd_d;
                            rem_q   <= prem_d;
                            dz_q    <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state flops, so they follow
    // reset immediately and never glitch from input activity.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule
